ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Parametrised PS/2 host-to-device command transmitter; successor to the fixed single-purpose keyboard reset responder.
- Sends any 8-bit command byte using the full host-to-device protocol:
  - clock inhibit
  - request-to-send
  - bit shifting on device clock
  - odd parity
  - stop bit
  - ack check
- Adds line-activity timeout and automatic retry on NACK/timeout.
- Sits between keyboard control logic (e.g. sends 0xFF reset, 0xED LED set) and the open-drain PS/2 pad drivers.

Parameters:
- INHIBIT_COUNT, 6000, clk cycles ps2_clk is held low before request-to-send (≥100 µs at system clock).
- TIMEOUT_COUNT, 120000, max clk cycles allowed between successive device clock falling edges (and for the first edge) before abort.
- COUNT_WIDTH, 17, bits of the shared cycle counter; must hold max(INHIBIT_COUNT, TIMEOUT_COUNT).
- MAX_RETRIES, 2, extra attempts after NACK or timeout; 0 disables retry.
- RETRY_WIDTH, 2, bits of the retry counter; must hold MAX_RETRIES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; rst==0 at a posedge resets the block.
- cmd_valid  in  1  request to send cmd_byte.
- cmd_byte  in  8  command byte; captured when cmd_valid && cmd_ready.
- cmd_ready  out  1  high in IDLE only.
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_pulldown  out  1  1 = drive PS/2 clock low.
- ps2_data_pulldown  out  1  1 = drive PS/2 data low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: transfer acknowledged by device.
- error  out  1  one-cycle pulse: all attempts failed.

Behaviour:
- Reset (rst==0):
  - state=IDLE; all counters 0; synchronisers set to 1.
  - ps2_clk_pulldown=0, ps2_data_pulldown=0, busy=0, done=0, error=0, cmd_ready=1.
  - Reset mid-transfer releases both lines on the next posedge.
- Inputs pass through 2-flop synchronisers. A falling edge (fe) is synced-prev==1 && synced-now==0. This gives 2–3 cycles of edge latency, which is acceptable.
- Handshake:
  - Accept on the posedge where cmd_valid && cmd_ready.
  - Byte and odd parity (~^cmd_byte) are latched; retry counter is cleared.
  - cmd_valid while busy is ignored, not queued.
- States:
  - IDLE: lines released. On accept → INHIBIT with counter=0; ps2_clk_pulldown=1 from the next cycle.
  - INHIBIT:
    - Counter increments each cycle.
    - When counter==INHIBIT_COUNT-1, set ps2_data_pulldown=1 (start bit) → RTS.
  - RTS: one cycle with data still low; release clock (ps2_clk_pulldown=0); clear counter, bit index=0 → SHIFT.
  - SHIFT:
    - On each fe, drive bit[idx]: ps2_data_pulldown = ~bit, LSB first; idx++.
    - After idx 7 is driven → PARITY.
  - PARITY: on fe, ps2_data_pulldown = ~parity → STOP.
  - STOP: on fe, ps2_data_pulldown=0 (stop bit 1) → ACK.
  - ACK: on fe, sample synced data:
    - 0 = ack → WAIT_IDLE.
    - 1 = nack → FAIL.
  - WAIT_IDLE: wait until synced clk and data are both 1 → IDLE, pulse done.
  - FAIL:
    - Lines released.
    - If retry count < MAX_RETRIES: increment it, → INHIBIT with the same byte.
    - Otherwise → IDLE, pulse error.
- Timeout:
  - In SHIFT, PARITY, STOP, ACK and WAIT_IDLE, the counter increments each cycle and clears on every fe.
  - Counter==TIMEOUT_COUNT-1 → FAIL; lines released the next cycle.
- ps2_clk_pulldown and ps2_data_pulldown are never both driven by the host outside INHIBIT/RTS.
- done and error are mutually exclusive and never high for more than one cycle.
- Counters saturate-free: widths are sized by parameters and compared by equality only.

Test Plan:
- Send 0xFF with a device model clocking ~12 kHz and acking:
  - Clock held low exactly INHIBIT_COUNT cycles.
  - Device samples start 0, data 1,1,1,1,1,1,1,1, parity 1, stop 1.
  - done pulses once; cmd_ready returns high.
- Send 0xF4: device sees bits 0,0,1,0,1,1,1,1 (LSB first), parity 0. Send 0xED: parity 1. Both get done.
- Device NACKs (data high at 11th fe) on every attempt, MAX_RETRIES=2:
  - Exactly 3 inhibit phases.
  - error pulses once, done never pulses.
- Device silent after RTS: FAIL after TIMEOUT_COUNT cycles; with MAX_RETRIES=0, error pulses and both pulldowns are 0.
- rst driven low during SHIFT at bit 4: next posedge has both pulldowns 0, busy 0, cmd_ready 1; a new 0xFF send then completes normally.
- cmd_valid held high with 0x55 while busy sending 0xFF: only 0xFF is transmitted; 0x55 is accepted on the first cycle back in IDLE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, LSB-first byte,
// odd parity, stop bit and ack check, with a line-activity timeout and bounded retry.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_COUNT = 6000,
    parameter int unsigned TIMEOUT_COUNT = 120000,
    parameter int unsigned COUNT_WIDTH   = 17,
    parameter int unsigned MAX_RETRIES   = 2,
    parameter int unsigned RETRY_WIDTH   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_pulldown,
    output logic       ps2_data_pulldown,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int unsigned IDX_WIDTH = 3;
    localparam logic [COUNT_WIDTH-1:0] INHIBIT_LAST = COUNT_WIDTH'(INHIBIT_COUNT - 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_COUNT - 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_LAST   = RETRY_WIDTH'(MAX_RETRIES);
    localparam logic [IDX_WIDTH-1:0]   IDX_LAST     = IDX_WIDTH'(7);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, RTS, SHIFT, PARITY, STOP, ACK, WAIT_IDLE, FAIL
    } state_t;

    state_t                 state, state_n;
    logic [COUNT_WIDTH-1:0] cnt, cnt_n;
    logic [RETRY_WIDTH-1:0] retry, retry_n;
    logic [IDX_WIDTH-1:0]   idx, idx_n;
    logic [7:0]             byte_q, byte_n;
    logic                   parity_q, parity_n;
    logic                   clk_pd_n, data_pd_n, done_n, error_n;
    logic [1:0]             clk_sync, data_sync;
    logic                   clk_prev;
    logic                   clk_s, data_s, fe;

    // Two-flop synchronisers on the raw lines plus falling-edge detect on the clock
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fe     = clk_prev & ~clk_s;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            retry             <= '0;
            idx               <= '0;
            byte_q            <= '0;
            parity_q          <= 1'b0;
            ps2_clk_pulldown  <= 1'b0;
            ps2_data_pulldown <= 1'b0;
            busy              <= 1'b0;
            cmd_ready         <= 1'b1;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            retry             <= retry_n;
            idx               <= idx_n;
            byte_q            <= byte_n;
            parity_q          <= parity_n;
            ps2_clk_pulldown  <= clk_pd_n;
            ps2_data_pulldown <= data_pd_n;
            busy              <= (state_n != IDLE);
            cmd_ready         <= (state_n == IDLE);
            done              <= done_n;
            error             <= error_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        retry_n   = retry;
        idx_n     = idx;
        byte_n    = byte_q;
        parity_n  = parity_q;
        data_pd_n = ps2_data_pulldown;
        done_n    = 1'b0;
        error_n   = 1'b0;

        case (state)
            IDLE: begin
                data_pd_n = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    state_n  = INHIBIT;
                    cnt_n    = '0;
                    retry_n  = '0;
                    byte_n   = cmd_byte;
                    parity_n = ~^cmd_byte;
                end
            end
            INHIBIT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == INHIBIT_LAST) begin
                    state_n   = RTS;
                    data_pd_n = 1'b1;
                end
            end
            RTS: begin
                state_n = SHIFT;
                cnt_n   = '0;
                idx_n   = '0;
            end
            SHIFT, PARITY, STOP, ACK, WAIT_IDLE: begin
                // Device-clocked phases share the inter-edge timeout
                cnt_n = fe ? '0 : cnt + 1'b1;
                if (state == WAIT_IDLE && clk_s && data_s) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (fe && state == SHIFT) begin
                    data_pd_n = ~byte_q[idx];
                    idx_n     = idx + 1'b1;
                    if (idx == IDX_LAST) state_n = PARITY;
                end else if (fe && state == PARITY) begin
                    data_pd_n = ~parity_q;
                    state_n   = STOP;
                end else if (fe && state == STOP) begin
                    data_pd_n = 1'b0;
                    state_n   = ACK;
                end else if (fe && state == ACK) begin
                    state_n = data_s ? FAIL : WAIT_IDLE;
                end else if (!fe && cnt == TIMEOUT_LAST) begin
                    state_n   = FAIL;
                    data_pd_n = 1'b0;
                end
            end
            FAIL: begin
                data_pd_n = 1'b0;
                if (retry != RETRY_LAST) begin
                    retry_n = retry + 1'b1;
                    cnt_n   = '0;
                    state_n = INHIBIT;
                end else begin
                    state_n = IDLE;
                    error_n = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                data_pd_n = 1'b0;
            end
        endcase

        clk_pd_n = (state_n == INHIBIT);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model records each frame, a scoreboard
// predicts frames from the sent bytes, and a per-cycle monitor checks output invariants.
module tb_ps2_host_tx;
    localparam int unsigned INH    = 40;
    localparam int unsigned TMO    = 200;
    localparam int unsigned CW     = 8;
    localparam int          BUDGET = 20000;
    localparam int          DEV_ACK = 0, DEV_NACK = 1, DEV_SILENT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_ready, clk_pd, data_pd, busy, done, error;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    logic       cmd_valid0;
    logic [7:0] cmd_byte0;
    logic       cmd_ready0, clk_pd0, data_pd0, busy0, done0, error0;

    int          vectors = 0, miscompares = 0;
    int          done_cnt = 0, err_cnt = 0, phases = 0;
    int          dev_mode = DEV_ACK;
    int          dev_fe_cnt = 0;
    bit          dev_busy = 1'b0;
    bit          mon_en = 1'b0;
    logic [10:0] frames[$];

    assign ps2_clk_line  = !(clk_pd || dev_clk_low);
    assign ps2_data_line = !(data_pd || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_COUNT(INH), .TIMEOUT_COUNT(TMO), .COUNT_WIDTH(CW),
                  .MAX_RETRIES(2), .RETRY_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
        .ps2_clk_pulldown(clk_pd), .ps2_data_pulldown(data_pd),
        .busy(busy), .done(done), .error(error));

    // No-retry instance with nothing but its own pulldowns on the lines
    ps2_host_tx #(.INHIBIT_COUNT(INH), .TIMEOUT_COUNT(TMO), .COUNT_WIDTH(CW),
                  .MAX_RETRIES(0), .RETRY_WIDTH(2)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_byte(cmd_byte0),
        .cmd_ready(cmd_ready0), .ps2_clk_in(!clk_pd0), .ps2_data_in(!data_pd0),
        .ps2_clk_pulldown(clk_pd0), .ps2_data_pulldown(data_pd0),
        .busy(busy0), .done(done0), .error(error0));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected frame as sampled by the device: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Device: waits for request-to-send, clocks 11 pulses, samples on rising edges, acks
    initial begin : device
        int          half, dly;
        logic [10:0] frame;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && dev_mode != DEV_SILENT && !dev_busy && ps2_clk_line && !ps2_data_line) begin
                dev_busy = 1'b1;
                half = int'($urandom_range(12, 25));
                dly  = int'($urandom_range(5, 40));
                repeat (dly) @(negedge clk);
                frame[0] = ps2_data_line;
                for (int k = 1; k <= 11; k++) begin
                    dev_clk_low = 1'b1;
                    dev_fe_cnt  = k;
                    repeat (half) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 10) frame[k] = ps2_data_line;
                    if (k == 10 && dev_mode == DEV_ACK) dev_data_low = 1'b1;
                    repeat (half) @(negedge clk);
                end
                dev_data_low = 1'b0;
                dev_fe_cnt   = 0;
                frames.push_back(frame);
                dev_busy = 1'b0;
            end
        end
    end

    // Per-cycle output invariants and inhibit-phase length
    initial begin : monitor
        int inh_run = 0;
        bit done_d = 1'b0, err_d = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
                chk("done_error_excl", 32'(done && error), 0);
                chk("done_one_cycle", 32'(done_d && done), 0);
                chk("error_one_cycle", 32'(err_d && error), 0);
                chk("pulldown_overlap", 32'(clk_pd && data_pd), 0);
                if (!busy) chk("idle_released", 32'({clk_pd, data_pd}), 0);
                if (clk_pd) inh_run++;
                else if (inh_run != 0) begin
                    chk("inhibit_len", 32'(inh_run), 32'(INH));
                    phases++;
                    inh_run = 0;
                end
                if (done) done_cnt++;
                if (error) err_cnt++;
                done_d = done;
                err_d  = error;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < BUDGET) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_result(output bit d, output bit e);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && !error && n < BUDGET);
        d = done;
        e = error;
        if (!d && !e) begin
            vectors++;
            miscompares++;
            $display("FAIL result_wait: no done or error within %0d cycles", BUDGET);
        end
    endtask

    task automatic wait_dev_idle();
        int n = 0;
        while (dev_busy && n < BUDGET) begin @(negedge clk); n++; end
        if (dev_busy) begin
            vectors++;
            miscompares++;
            $display("FAIL device_idle: device still busy after %0d cycles", BUDGET);
        end
    endtask

    task automatic check_frame(input string name, input logic [10:0] exp);
        logic [10:0] f;
        if (frames.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no frame captured, expected %h", name, exp);
        end else begin
            f = frames.pop_front();
            chk(name, 32'(f), 32'(exp));
        end
    endtask

    task automatic do_ack(input string name, input logic [7:0] b, input logic [10:0] exp);
        int d0, e0, p0;
        bit d, e;
        d0 = done_cnt; e0 = err_cnt; p0 = phases;
        send(b);
        wait_result(d, e);
        chk({name, "_done"}, 32'(d), 1);
        chk({name, "_error"}, 32'(e), 0);
        chk({name, "_ready_back"}, 32'(cmd_ready), 1);
        @(negedge clk);
        wait_dev_idle();
        check_frame({name, "_frame"}, exp);
        chk({name, "_inhibits"}, 32'(phases - p0), 1);
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
        chk({name, "_error_pulses"}, 32'(err_cnt - e0), 0);
    endtask

    initial begin : main
        bit          d, e;
        int          n, d0, e0, p0;
        logic [7:0]  b;

        rst = 1'b0; cmd_valid = 1'b0; cmd_byte = 8'h00;
        cmd_valid0 = 1'b0; cmd_byte0 = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulldowns", 32'({clk_pd, data_pd}), 0);
        chk("rst_pulses", 32'({done, error}), 0);
        chk("rst_ready0", 32'(cmd_ready0), 1);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Fixed commands against hand-computed frames
        dev_mode = DEV_ACK;
        do_ack("cmd_ff", 8'hFF, 11'h7FE);
        do_ack("cmd_f4", 8'hF4, 11'h5E8);
        do_ack("cmd_ed", 8'hED, 11'h7DA);

        // Random commands against the frame model
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            do_ack("rand", b, model_frame(b));
        end

        // Device NACKs every attempt: three attempts, one error
        dev_mode = DEV_NACK;
        b = 8'($urandom_range(0, 255));
        d0 = done_cnt; e0 = err_cnt; p0 = phases;
        send(b);
        wait_result(d, e);
        chk("nack_error", 32'(e), 1);
        chk("nack_done", 32'(d), 0);
        @(negedge clk);
        wait_dev_idle();
        for (int i = 0; i < 3; i++) check_frame("nack_frame", model_frame(b));
        chk("nack_extra_frames", 32'(frames.size()), 0);
        chk("nack_inhibits", 32'(phases - p0), 3);
        chk("nack_error_pulses", 32'(err_cnt - e0), 1);
        chk("nack_done_pulses", 32'(done_cnt - d0), 0);

        // Silent device with retries
        dev_mode = DEV_SILENT;
        d0 = done_cnt; e0 = err_cnt; p0 = phases;
        send(8'h3C);
        wait_result(d, e);
        chk("silent_error", 32'(e), 1);
        @(negedge clk);
        chk("silent_inhibits", 32'(phases - p0), 3);
        chk("silent_done_pulses", 32'(done_cnt - d0), 0);
        chk("silent_frames", 32'(frames.size()), 0);

        // No-retry instance: inhibit, one RTS cycle, full timeout, one FAIL cycle
        @(negedge clk);
        cmd_valid0 = 1'b1;
        @(posedge clk);
        #1 cmd_valid0 = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!error0 && n < BUDGET);
        chk("timeout_cycles", 32'(n), 32'(INH + TMO + 2));
        chk("timeout_pulldowns", 32'({clk_pd0, data_pd0}), 0);
        chk("timeout_busy", 32'(busy0), 0);
        chk("timeout_done", 32'(done0), 0);

        // Reset during SHIFT while bit 4 is on the line
        dev_mode = DEV_ACK;
        send(8'hFF);
        n = 0;
        while (!(dev_busy && dev_fe_cnt == 5) && n < BUDGET) begin @(negedge clk); n++; end
        chk("reset_reached_bit4", 32'(dev_fe_cnt), 5);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pulldowns", 32'({clk_pd, data_pd}), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        wait_dev_idle();
        frames.delete();
        do_ack("after_reset", 8'hFF, 11'h7FE);

        // cmd_valid held with a second byte while busy
        @(negedge clk);
        cmd_byte = 8'hFF;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < BUDGET) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 cmd_byte = 8'h55;
        wait_result(d, e);
        chk("held_first_done", 32'(d), 1);
        chk("held_ready_at_done", 32'(cmd_ready), 1);
        @(negedge clk);
        chk("held_accept_busy", 32'(busy), 1);
        chk("held_accept_inhibit", 32'(clk_pd), 1);
        cmd_valid = 1'b0;
        wait_dev_idle();
        check_frame("held_first_frame", 11'h7FE);
        wait_result(d, e);
        chk("held_second_done", 32'(d), 1);
        @(negedge clk);
        wait_dev_idle();
        check_frame("held_second_frame", 11'h6AA);
        chk("held_no_extra", 32'(frames.size()), 0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
